// File: rtl/tank_sprite_index_gen.sv
// Tank sprite index generator: per-pixel sprite hit test, oriented/animated ROM address, palette index out.
// Latency 3 cycles (rom_addr at t+1), 1 pixel/cycle, no backpressure. Optional blink: define TANK_FLASH_EN.
module tank_sprite_index_gen #(
  parameter int SPRITE_W = 32,
  parameter int ANIM_DIV = 8,
  parameter int ADDR_W   = 11
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        tank_x,
  input  logic [9:0]        tank_y,
  input  logic [1:0]        tank_dir,
  input  logic              moving,
`ifdef TANK_FLASH_EN
  input  logic              flash,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  output logic              sprite_on,
  output logic              out_valid
);

  localparam int              CNT_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ANIM_DIV - 1);
  localparam logic [9:0]      W10     = 10'(SPRITE_W);
  localparam logic [9:0]      WM1     = 10'(SPRITE_W - 1);

  logic [9:0]        x_l_q, x_l_d, y_l_q, y_l_d;
  logic [1:0]        dir_l_q, dir_l_d;
  logic              mov_l_q, mov_l_d;
  logic [CNT_W-1:0]  anim_cnt_q, anim_cnt_d;
  logic              anim_frame_q, anim_frame_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, v1_q, hit2_q, v2_q;
  logic [3:0]        pal_q, pal_d;
  logic              on_q, on_d;
  logic              out_valid_q;
`ifdef TANK_FLASH_EN
  logic [1:0]        flash_cnt_q, flash_cnt_d;
`endif

  logic [9:0]  rx, ry, u, v;
  logic        hit;
  logic [31:0] addr_full;

  always_comb begin
    x_l_d        = x_l_q;
    y_l_d        = y_l_q;
    dir_l_d      = dir_l_q;
    mov_l_d      = mov_l_q;
    anim_cnt_d   = anim_cnt_q;
    anim_frame_d = anim_frame_q;
`ifdef TANK_FLASH_EN
    flash_cnt_d  = flash_cnt_q;
`endif
    if (frame_start) begin
      x_l_d   = tank_x;
      y_l_d   = tank_y;
      dir_l_d = tank_dir;
      mov_l_d = moving;
`ifdef TANK_FLASH_EN
      flash_cnt_d = flash_cnt_q + 2'd1;
`endif
      // Animation advances on the freshly latched moving flag.
      if (moving) begin
        if (anim_cnt_q == CNT_MAX) begin
          anim_cnt_d   = '0;
          anim_frame_d = ~anim_frame_q;
        end else begin
          anim_cnt_d = anim_cnt_q + 1'b1;
        end
      end
    end
  end

  // Offsets wrap modulo 1024, so pixels left of / above the sprite miss.
  always_comb begin
    rx  = DrawX - x_l_q;
    ry  = DrawY - y_l_q;
    hit = pix_valid && (rx < W10) && (ry < W10);
    u   = rx;
    v   = ry;
    case (dir_l_q)
      2'd0: begin u = ry;       v = rx; end
      2'd1: begin u = WM1 - rx; v = ry; end
      2'd2: begin u = WM1 - ry; v = rx; end
      default: begin u = rx;    v = ry; end
    endcase
    addr_full  = 32'(anim_frame_q) * 32'(SPRITE_W * SPRITE_W) + 32'(v) * 32'(SPRITE_W) + 32'(u);
    rom_addr_d = hit ? addr_full[ADDR_W-1:0] : '0;
  end

  // Palette index 0 is the transparent key.
  always_comb begin
    pal_d = hit2_q ? rom_data : 4'd0;
    on_d  = hit2_q && (rom_data != 4'd0);
`ifdef TANK_FLASH_EN
    if (flash && flash_cnt_q[1]) on_d = 1'b0;
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      x_l_q        <= '0;
      y_l_q        <= '0;
      dir_l_q      <= '0;
      mov_l_q      <= 1'b0;
      anim_cnt_q   <= '0;
      anim_frame_q <= 1'b0;
      rom_addr_q   <= '0;
      hit1_q       <= 1'b0;
      v1_q         <= 1'b0;
      hit2_q       <= 1'b0;
      v2_q         <= 1'b0;
      pal_q        <= '0;
      on_q         <= 1'b0;
      out_valid_q  <= 1'b0;
`ifdef TANK_FLASH_EN
      flash_cnt_q  <= '0;
`endif
    end else begin
      x_l_q        <= x_l_d;
      y_l_q        <= y_l_d;
      dir_l_q      <= dir_l_d;
      mov_l_q      <= mov_l_d;
      anim_cnt_q   <= anim_cnt_d;
      anim_frame_q <= anim_frame_d;
      rom_addr_q   <= rom_addr_d;
      hit1_q       <= hit;
      v1_q         <= pix_valid;
      hit2_q       <= hit1_q;
      v2_q         <= v1_q;
      pal_q        <= pal_d;
      on_q         <= on_d;
      out_valid_q  <= v2_q;
`ifdef TANK_FLASH_EN
      flash_cnt_q  <= flash_cnt_d;
`endif
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pal_index = pal_q;
  assign sprite_on = on_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tank_sprite_index_gen.sv
// Directed bench for tank_sprite_index_gen with a registered ROM model holding word i = (7*i+5) mod 16.
module tb_tank_sprite_index_gen;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  DrawX, DrawY, tank_x, tank_y;
  logic [1:0]  tank_dir;
  logic        moving;
  logic [10:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pal_index;
  logic        sprite_on;
  logic        out_valid;
`ifdef TANK_FLASH_EN
  logic        flash;
`endif

  logic [3:0] rom [0:2047];
  int checks = 0;
  int errors = 0;

  tank_sprite_index_gen dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .tank_x(tank_x), .tank_y(tank_y),
    .tank_dir(tank_dir), .moving(moving),
`ifdef TANK_FLASH_EN
    .flash(flash),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .pal_index(pal_index),
    .sprite_on(sprite_on), .out_valid(out_valid)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame(input int x, input int y, input int dir, input int mov);
    tank_x = 10'(x); tank_y = 10'(y); tank_dir = 2'(dir); moving = mov[0];
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One isolated pixel: rom_addr checked at t+1, outputs at t+3.
  task automatic pix(input string tag, input int x, input int y, input int vld,
                     input int exp_addr, input int exp_pal, input int exp_on);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = vld[0];
    tick();
    pix_valid = 1'b0; DrawX = '0; DrawY = '0;
    check_val({tag, ".addr"}, int'(rom_addr), exp_addr);
    tick();
    tick();
    check_val({tag, ".pal"}, int'(pal_index), exp_pal);
    check_val({tag, ".on"}, int'(sprite_on), exp_on);
    check_val({tag, ".vld"}, int'(out_valid), vld);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 4'((7 * i + 5) % 16);
    Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    DrawX = '0; DrawY = '0; tank_x = '0; tank_y = '0; tank_dir = '0; moving = 1'b0;
`ifdef TANK_FLASH_EN
    flash = 1'b0;
`endif
    repeat (3) tick();
    check_val("rst.addr", int'(rom_addr), 0);
    check_val("rst.pal", int'(pal_index), 0);
    check_val("rst.on", int'(sprite_on), 0);
    check_val("rst.vld", int'(out_valid), 0);
    Reset_n = 1'b1;
    tick();

    frame(100, 100, 3, 0);
    pix("origin", 100, 100, 1, 0, 5, 1);

    pix("left", 103, 101, 1, 35, 10, 1);
    frame(100, 100, 1, 0);
    pix("right", 103, 101, 1, 60, 9, 1);
    frame(100, 100, 0, 0);
    pix("up", 103, 101, 1, 97, 12, 1);
    frame(100, 100, 2, 0);
    pix("down", 103, 101, 1, 126, 7, 1);

    frame(100, 100, 3, 0);
    pix("miss_x99", 99, 100, 1, 0, 0, 0);
    pix("miss_x132", 132, 100, 1, 0, 0, 0);
    pix("miss_y132", 100, 132, 1, 0, 0, 0);
    pix("novalid", 100, 100, 0, 0, 0, 0);
    pix("transp", 113, 100, 1, 13, 0, 0);

    frame(630, 100, 3, 0);
    pix("edge_hit", 639, 100, 1, 9, 4, 1);
    pix("edge_nowrap", 5, 100, 1, 0, 0, 0);

    // Latch timing: mid-frame tank_x change is ignored until frame_start.
    frame(100, 100, 3, 0);
    tank_x = 10'd200;
    pix("midframe", 103, 101, 1, 35, 10, 1);
    DrawX = 10'd103; DrawY = 10'd101; pix_valid = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; pix_valid = 1'b0;
    check_val("samecyc.addr", int'(rom_addr), 35);
    tick();
    tick();
    check_val("samecyc.on", int'(sprite_on), 1);
    pix("newx_old", 103, 101, 1, 0, 0, 0);
    pix("newx_new", 203, 101, 1, 35, 10, 1);

    // Animation: 8 moving frames toggle the tread frame, still frames hold it.
    for (int i = 0; i < 8; i++) frame(100, 100, 3, 1);
    pix("anim1", 100, 100, 1, 1024, 5, 1);
    for (int i = 0; i < 20; i++) frame(100, 100, 3, 0);
    pix("anim_hold", 100, 100, 1, 1024, 5, 1);

    // Reset with a pixel in flight discards the pipeline.
    DrawX = 10'd103; DrawY = 10'd101; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    check_val("inflight.addr", int'(rom_addr), 1059);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    check_val("midrst.addr", int'(rom_addr), 0);
    check_val("midrst.pal", int'(pal_index), 0);
    check_val("midrst.on", int'(sprite_on), 0);
    check_val("midrst.vld", int'(out_valid), 0);
    tick();
    tick();
    check_val("midrst.drain", int'(out_valid), 0);

`ifdef TANK_FLASH_EN
    flash = 1'b1;
    frame(100, 100, 3, 0);
    pix("flash_c1", 100, 100, 1, 0, 5, 1);
    frame(100, 100, 3, 0);
    pix("flash_c2", 100, 100, 1, 0, 5, 0);
    frame(100, 100, 3, 0);
    pix("flash_c3", 100, 100, 1, 0, 5, 0);
    frame(100, 100, 3, 0);
    pix("flash_c0", 100, 100, 1, 0, 5, 1);
    flash = 1'b0;
    frame(100, 100, 3, 0);
    pix("flash_off", 100, 100, 1, 0, 5, 1);
`else
    frame(100, 100, 3, 0);
    pix("postrst", 100, 100, 1, 0, 5, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tank_sprite_index_gen.md
Name: tank_sprite_index_gen

Overview:
- Upstream feeder of the tank palette lookup. For each VGA pixel it decides whether the pixel falls inside the tank sprite and computes the sprite ROM address, including facing direction and tread animation frame.
- It returns the 4-bit palette index read back from the ROM, plus a sprite_on flag.
- Sits between the VGA controller/tank motion logic and the palette ROM → color mux.

Parameters:
- SPRITE_W, 32, sprite width and height in pixels; the sprite is square.
- ANIM_DIV, 8, number of moving frames per tread-animation toggle; must be ≥ 1.
- ADDR_W, 11, ROM address width; must equal log2(2*SPRITE_W*SPRITE_W).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_valid  in  1  DrawX/DrawY valid this cycle
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- tank_x  in  10  sprite top-left column (live)
- tank_y  in  10  sprite top-left row (live)
- tank_dir  in  2  0=up 1=right 2=down 3=left
- moving  in  1  tank moved this frame
- rom_addr  out  ADDR_W  sprite ROM address
- rom_data  in  4  ROM output, registered inside the ROM (1-cycle read)
- pal_index  out  4  palette index for the palette block
- sprite_on  out  1  pixel is opaque tank pixel
- out_valid  out  1  pal_index/sprite_on valid

Behaviour:
- Reset (Reset_n=0 at edge):
  - Clears all registers.
  - rom_addr=0, pal_index=0, sprite_on=0, out_valid=0.
  - Latched position, direction and moving = 0; anim_frame=0; anim_cnt=0.
- Frame latch:
  - On the edge where frame_start=1, capture tank_x, tank_y, tank_dir and moving into x_l, y_l, dir_l, mov_l.
  - Pixels in that same cycle use the old latched values.
  - Mid-frame changes on tank_* are ignored.
- Animation (evaluated on the frame_start edge, after the latch update, using the newly latched mov_l):
  - If mov_l=1: anim_cnt increments. When it reaches ANIM_DIV-1 it wraps to 0 and anim_frame toggles.
  - If mov_l=0: anim_cnt and anim_frame hold.
- Stage 0 (combinational on inputs):
  - rx = DrawX − x_l, ry = DrawY − y_l, both 10-bit modulo arithmetic.
  - hit = pix_valid && rx < SPRITE_W && ry < SPRITE_W. Negative offsets wrap to large values, so they miss.
- Orientation (ROM stores the left-facing art), with W = SPRITE_W:
  - left: u=rx, v=ry
  - right: u=W−1−rx, v=ry
  - up: u=ry, v=rx
  - down: u=W−1−ry, v=rx
- Address: addr = anim_frame·W·W + v·W + u, truncated to ADDR_W.
- Stage 1 register:
  - rom_addr ← hit ? addr : 0.
  - hit1 ← hit; v1 ← pix_valid.
- Stage 2: ROM presents rom_data for rom_addr; hit2/v2 are delayed copies.
- Stage 3 register:
  - pal_index ← hit2 ? rom_data : 0.
  - sprite_on ← hit2 && rom_data≠0 (index 0 is the transparent key).
  - out_valid ← v2.
- Latency: a pixel presented in cycle t has rom_addr in cycle t+1 and outputs in cycle t+3. Throughput is 1 pixel/cycle with no stalls.
- Boundaries:
  - Sprite partly off-screen (x_l > 640−W): the visible portion renders; there is no wrap to the left edge, because rx stays non-negative only for on-sprite columns.
  - pix_valid=0: out_valid=0 three cycles later, and sprite_on=0.
  - Reset mid-line: pipeline contents are discarded; outputs are 0 on the cycle after the reset edge.

Optional Feature:
- Macro: TANK_FLASH_EN.
- With the macro defined:
  - Adds input port flash (1 bit) and a 2-bit flash_cnt that increments on every frame_start edge.
  - While flash=1 and flash_cnt[1]=1, sprite_on is forced 0 (pal_index unchanged), giving a 2-frames-on / 2-frames-off blink for damage or respawn.
  - flash_cnt resets to 0.
- Without the macro: no flash port, no counter, sprite_on as specified above.

Test Plan:
- Reset → all outputs 0. Then x=100,y=100,dir=3 latched via frame_start; DrawX=100,DrawY=100,pix_valid=1 → rom_addr=0 at t+1; with ROM word0=5, pal_index=5, sprite_on=1, out_valid=1 at t+3.
- Orientation, same latch with DrawX=103,DrawY=101 (rx=3, ry=1):
  - dir=3 → rom_addr=35
  - dir=1 → rom_addr=60
  - dir=0 → rom_addr=97
  - dir=2 → rom_addr=126
- Bounds: DrawX=99 or 132, or DrawY=132 → rom_addr=0, sprite_on=0, pal_index=0. With x=630, DrawX=639 → hit (rx=9), DrawX=5 → miss.
- Animation: moving=1 held for 8 frame_start pulses → anim_frame=1, and pixel (100,100) left-facing gives rom_addr=1024. Then moving=0 for 20 frames → stays 1024.
- Latch timing: change tank_x to 200 mid-frame → pixels still hit at 100 until the next frame_start. Pixel in the same cycle as frame_start uses x_l=100.
- Transparency/flash: ROM word=0 → sprite_on=0, pal_index=0. With TANK_FLASH_EN and flash=1, sprite_on is 0 during frames where flash_cnt=2,3 and normal during frames where flash_cnt=0,1.
